// File: rtl/fab_clken_ccc.sv
// fab_clken_ccc: fabric-side clock conditioning for the CCC fabric clock.
// The CCC lock indication passes through a two-flop synchroniser and must
// hold for LOCK_CNT consecutive cycles before the block enters RUN. In RUN
// it produces NCH programmable, phase-aligned clock-enable strobes.
// FAB_RESET is held high whenever the block is not in RUN.
// Optional feature macro: FAB_CLKEN_LOSS_CNT_EN. When it is defined, a
// saturating lock-loss event counter drives LOSS_CNT. Without it, LOSS_CNT
// is tied to zero.

module fab_clken_ccc #(
  parameter int NCH      = 3,
  parameter int DIVW     = 8,
  parameter int LOCK_CNT = 1024
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                LOCK_IN,
  input  logic [NCH*DIVW-1:0] DIV,
  input  logic                DIV_LOAD,
  input  logic                CLR_LOST,
  output logic [NCH-1:0]      CLKEN,
  output logic                LOCKED,
  output logic                FAB_RESET,
  output logic                LOCK_LOST,
  output logic [7:0]          LOSS_CNT
);

  // The qualify counter only needs to reach LOCK_CNT-1.
  localparam int QW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam logic [QW-1:0] Q_LAST = QW'(LOCK_CNT - 1);

  typedef enum logic [1:0] {
    RST_ST,
    WAIT_LOCK,
    QUALIFY,
    RUN
  } state_t;

  state_t          state;
  state_t          next_state;
  logic            sync1;
  logic            sync2;
  logic [QW-1:0]   qual_cnt;
  logic            locked_q;
  logic            lock_lost_q;
  logic            loss_event;
  logic [DIVW-1:0] shadow [NCH];
  logic [DIVW-1:0] phase  [NCH];

  // Two-flop synchroniser for the asynchronous CCC lock signal.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= LOCK_IN;
      sync2 <= sync1;
    end
  end

  // Lock-qualification FSM state register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= RST_ST;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode. Only the synchronised lock (sync2) steers the FSM.
  always_comb begin
    next_state = state;
    case (state)
      RST_ST: begin
        next_state = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (sync2) begin
          next_state = QUALIFY;
        end
      end
      QUALIFY: begin
        if (!sync2) begin
          next_state = WAIT_LOCK;
        end else if (qual_cnt == Q_LAST) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (!sync2) begin
          next_state = WAIT_LOCK;
        end
      end
      default: begin
        next_state = RST_ST;
      end
    endcase
  end

  // Count consecutive qualifying cycles. Any other condition restarts the
  // count, so the counter is already 0 when QUALIFY is entered.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      qual_cnt <= '0;
    end else if ((state == QUALIFY) && sync2 && (qual_cnt != Q_LAST)) begin
      qual_cnt <= qual_cnt + QW'(1);
    end else begin
      qual_cnt <= '0;
    end
  end

  // A lock-loss event occurs when the lock drops while in RUN.
  assign loss_event = (state == RUN) && !sync2;

  // LOCKED is registered from the next state, so it tracks (state == RUN)
  // on the same edge that the state changes.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      locked_q <= 1'b0;
    end else begin
      locked_q <= (next_state == RUN);
    end
  end

  assign LOCKED    = locked_q;
  assign FAB_RESET = ~locked_q;

  // Sticky loss flag. A loss takes priority over a clear in the same cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      lock_lost_q <= 1'b0;
    end else if (loss_event) begin
      lock_lost_q <= 1'b1;
    end else if (CLR_LOST) begin
      lock_lost_q <= 1'b0;
    end
  end

  assign LOCK_LOST = lock_lost_q;

`ifdef FAB_CLKEN_LOSS_CNT_EN
  logic [7:0] loss_cnt_q;

  // Saturating loss counter. A loss coinciding with a clear leaves a count
  // of one.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      loss_cnt_q <= 8'd0;
    end else if (loss_event) begin
      if (CLR_LOST) begin
        loss_cnt_q <= 8'd1;
      end else if (loss_cnt_q != 8'hFF) begin
        loss_cnt_q <= loss_cnt_q + 8'd1;
      end
    end else if (CLR_LOST) begin
      loss_cnt_q <= 8'd0;
    end
  end

  assign LOSS_CNT = loss_cnt_q;
`else
  assign LOSS_CNT = 8'd0;
`endif

  // Shadow divide registers load in any state. Reset has priority over a
  // load.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NCH; i++) begin
        shadow[i] <= '0;
      end
    end else if (DIV_LOAD) begin
      for (int i = 0; i < NCH; i++) begin
        shadow[i] <= DIV[i*DIVW +: DIVW];
      end
    end
  end

  // Phase counters are held at 0 outside RUN, so all channels start aligned
  // on entry to RUN. A load realigns every channel. In RUN, each counter
  // wraps after reaching shadow-1. A disabled channel (shadow 0) stays at 0.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NCH; i++) begin
        phase[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (DIV_LOAD || (state != RUN)) begin
          phase[i] <= '0;
        end else if ((shadow[i] == '0) || (phase[i] == (shadow[i] - DIVW'(1)))) begin
          phase[i] <= '0;
        end else begin
          phase[i] <= phase[i] + DIVW'(1);
        end
      end
    end
  end

  // Strobe decode uses registers only: the RUN flag, the phase and the
  // channel-enabled test.
  always_comb begin
    CLKEN = '0;
    for (int i = 0; i < NCH; i++) begin
      CLKEN[i] = locked_q && (phase[i] == '0) && (shadow[i] != '0);
    end
  end

endmodule
